// File: rtl/compare_counter_if.sv
// Bus bundle for one compare channel: config/compare write strobes, main counter view,
// interrupt acknowledge, and the channel status/target returned to the device.
interface compare_counter_if;
  logic        conf_write;
  logic        conf_ena;
  logic        conf_irqena;
  logic        conf_periodic;
  logic        comp_write;
  logic [1:0]  comp_dqm_n;
  logic [63:0] comp_data;
  logic        main_working;
  logic [63:0] main_counter;
  logic        irq_ack;
  logic        working;
  logic        irq_valid;
  logic        overrun;
  logic [63:0] comp_counter;

  modport master (
    output conf_write, conf_ena, conf_irqena, conf_periodic,
    output comp_write, comp_dqm_n, comp_data,
    output main_working, main_counter, irq_ack,
    input  working, irq_valid, overrun, comp_counter
  );

  modport slave (
    input  conf_write, conf_ena, conf_irqena, conf_periodic,
    input  comp_write, comp_dqm_n, comp_data,
    input  main_working, main_counter, irq_ack,
    output working, irq_valid, overrun, comp_counter
  );
endinterface

// File: rtl/compare_counter.sv
// Compare/alarm channel for the utim64 timer: raises an interrupt when the main counter hits the target.
// Define UTIM64_CMP_PERIODIC_EN to add the period register and periodic re-arm; otherwise every match is one-shot.
module compare_counter (
  input logic              clk,
  input logic              rst_n,
  compare_counter_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t      state;
  logic [63:0] target;
  logic        irq_en;
  logic        irq_pending;
  logic        overrun_flag;
  logic        match;

`ifdef UTIM64_CMP_PERIODIC_EN
  logic        periodic;
  logic [63:0] period;
  logic [63:0] next_target;

  assign next_target = target + period;
`endif

  assign match = (state == ARMED) && bus.main_working && (bus.main_counter == target);

  // Compare writes only land in IDLE and matches only happen in ARMED, so the two never
  // fight over the target register within one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      target       <= 64'd0;
      irq_en       <= 1'b0;
      irq_pending  <= 1'b0;
      overrun_flag <= 1'b0;
`ifdef UTIM64_CMP_PERIODIC_EN
      periodic     <= 1'b0;
      period       <= 64'd0;
`endif
    end else begin
      if (bus.comp_write && (state == IDLE)) begin
        for (int h = 0; h < 2; h++) begin
          if (!bus.comp_dqm_n[h]) begin
            target[h*32 +: 32] <= bus.comp_data[h*32 +: 32];
`ifdef UTIM64_CMP_PERIODIC_EN
            period[h*32 +: 32] <= bus.comp_data[h*32 +: 32];
`endif
          end
        end
      end

      if (bus.conf_write) begin
        state        <= bus.conf_ena ? ARMED : IDLE;
        irq_en       <= bus.conf_irqena;
        overrun_flag <= 1'b0;
        if (!bus.conf_ena || bus.irq_ack) begin
          irq_pending <= 1'b0;
        end
`ifdef UTIM64_CMP_PERIODIC_EN
        periodic <= bus.conf_periodic;
        // A re-arm of an already periodic channel must not lose the pending advance.
        if (match && periodic && bus.conf_ena) begin
          target <= next_target;
        end
`endif
      end else if (match) begin
        if (irq_en) begin
          irq_pending <= 1'b1;
          if (irq_pending && !bus.irq_ack) begin
            overrun_flag <= 1'b1;
          end
        end else if (bus.irq_ack) begin
          irq_pending <= 1'b0;
        end
`ifdef UTIM64_CMP_PERIODIC_EN
        if (periodic) begin
          target <= next_target;
        end else begin
          state <= IDLE;
        end
`else
        state <= IDLE;
`endif
      end else if (bus.irq_ack) begin
        irq_pending <= 1'b0;
      end
    end
  end

  assign bus.working      = (state == ARMED);
  assign bus.irq_valid    = irq_pending;
  assign bus.overrun      = overrun_flag;
  assign bus.comp_counter = target;

endmodule
